// File: rtl/display_scan_ctrl.sv
// Scan driver for a 4-digit multiplexed 7-segment display.
// A prescaler divides clk down to one tick per digit slot. The 2-bit digit
// select advances on each tick. A frame-synchronous shadow of the four BCD
// digits is updated only when sel wraps from 3 back to 0, so the digits shown
// within one frame always come from the same value and never tear.
// All outputs are registered. digit and blank are updated on the same edge
// as sel, so the three outputs always describe the same slot.

module display_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,  // clk cycles per digit slot, >= 2
    parameter bit LZ_BLANK    = 1'b1    // blank leftmost digit when it is 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic [1:0]  sel,
    output logic [3:0]  digit,
    output logic        blank,
    output logic        frame_tick,
    output logic        load_ack
);

    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Prescaler and slot select.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;

    // Load path: staging holds the most recent load until the frame boundary.
    logic [15:0] staging_q, staging_d;
    logic [15:0] shadow_q,  shadow_d;
    logic        pending_q, pending_d;

    // Registered outputs.
    logic [3:0] digit_q, digit_d;
    logic       blank_q, blank_d;
    logic       frame_tick_q, frame_tick_d;
    logic       load_ack_q, load_ack_d;

    // Slot and frame events, and the nibble that the next slot will show.
    logic       tick;
    logic       wrap;
    logic       commit;
    logic [3:0] nibble_next;

    // Decode slot/frame events from the current count and select.
    always_comb begin
        tick   = en && (cnt_q == CNT_LAST);
        wrap   = tick && (sel_q == 2'd3);
        // A load in the wrap cycle itself is committed on that same wrap.
        commit = wrap && (pending_q || load);
    end

    // Prescaler counts while enabled and advances sel on each tick.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        cnt_d = cnt_q;
        sel_d = sel_q;
        if (en) begin
            if (tick) begin
                cnt_d = '0;
                sel_d = sel_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Buffered load path: the last load before a wrap wins, and it is committed at the wrap.
    always_comb begin
        staging_d = staging_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (load) begin
            staging_d = data_in;
        end
        if (commit) begin
            shadow_d  = load ? data_in : staging_q;
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Select the nibble that the next slot will show, using the new shadow on a wrap.
    always_comb begin
        nibble_next = 4'h0;
        unique case (sel_d)
            2'd0: nibble_next = shadow_d[15:12];
            2'd1: nibble_next = shadow_d[11:8];
            2'd2: nibble_next = shadow_d[7:4];
            2'd3: nibble_next = shadow_d[3:0];
        endcase
    end

    // Update digit and blank on the same edge as sel; disabling the scan blanks the display.
    always_comb begin
        digit_d      = digit_q;
        blank_d      = blank_q;
        frame_tick_d = wrap;
        load_ack_d   = commit;
        if (!en) begin
            blank_d = 1'b1;
        end else if (tick) begin
            digit_d = nibble_next;
            // Invalid BCD is still driven on digit, but the segments are blanked.
            blank_d = (nibble_next > 4'd9) ||
                      (LZ_BLANK && (sel_d == 2'd0) && (nibble_next == 4'd0));
        end
    end

    // State register; an asynchronous reset discards any pending load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            staging_q    <= 16'h0000;
            shadow_q     <= 16'h0000;
            pending_q    <= 1'b0;
            digit_q      <= 4'h0;
            blank_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge
            // values, so the order of these statements does not matter.
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            staging_q    <= staging_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            digit_q      <= digit_d;
            blank_q      <= blank_d;
            frame_tick_q <= frame_tick_d;
            load_ack_q   <= load_ack_d;
        end
    end

    assign sel        = sel_q;
    assign digit      = digit_q;
    assign blank      = blank_q;
    assign frame_tick = frame_tick_q;
    assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl with REFRESH_DIV=4 and LZ_BLANK=1.
// On every driven cycle, a reference model pushes the expected outputs into a
// scoreboard queue. After the next rising edge, the expected entry is popped
// and compared with the DUT outputs. Directed checks against fixed constants
// cover the reset state, load commit, and blanking scenarios.

module tb_display_scan_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [1:0]  sel;
    logic [3:0]  digit;
    logic        blank;
    logic        frame_tick;
    logic        load_ack;

    display_scan_ctrl #(
        .REFRESH_DIV(DIV),
        .LZ_BLANK   (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .data_in   (data_in),
        .load      (load),
        .sel       (sel),
        .digit     (digit),
        .blank     (blank),
        .frame_tick(frame_tick),
        .load_ack  (load_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] digit;
        logic       blank;
        logic       ftick;
        logic       ack;
    } exp_t;

    exp_t sb_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ack_cnt = 0;

    // Reference model state.
    int          m_cnt;
    logic [1:0]  m_sel;
    logic [15:0] m_shadow;
    logic [15:0] m_staging;
    bit          m_pending;
    logic [3:0]  m_digit;
    bit          m_blank;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] nib_of(input logic [15:0] v, input logic [1:0] s);
        logic [15:0] t;
        t = v >> (12 - 4 * int'(s));
        return t[3:0];
    endfunction

    task automatic model_reset();
        m_cnt     = 0;
        m_sel     = 2'd0;
        m_shadow  = 16'h0000;
        m_staging = 16'h0000;
        m_pending = 1'b0;
        m_digit   = 4'h0;
        m_blank   = 1'b1;
    endtask

    task automatic model_step(input bit e, input bit l, input logic [15:0] d, output exp_t x);
        bit          tk;
        bit          wr;
        bit          cm;
        logic [1:0]  nsel;
        logic [15:0] nshadow;
        logic [3:0]  n;
        tk      = e && (m_cnt == DIV - 1);
        wr      = tk && (m_sel == 2'd3);
        cm      = wr && (m_pending || l);
        nsel    = tk ? m_sel + 2'd1 : m_sel;
        nshadow = cm ? (l ? d : m_staging) : m_shadow;
        if (e) m_cnt = tk ? 0 : m_cnt + 1;
        if (l) m_staging = d;
        if (cm) m_pending = 1'b0;
        else if (l) m_pending = 1'b1;
        m_shadow = nshadow;
        m_sel    = nsel;
        if (!e) begin
            m_blank = 1'b1;
        end else if (tk) begin
            n       = nib_of(nshadow, nsel);
            m_digit = n;
            m_blank = (n > 4'd9) || (nsel == 2'd0 && n == 4'd0);
        end
        x = '{sel: m_sel, digit: m_digit, blank: m_blank, ftick: wr, ack: cm};
    endtask

    // Drive one cycle, push the model's expectation, then pop it and compare after the edge.
    task automatic step(input bit e, input bit l, input logic [15:0] d);
        exp_t x;
        @(negedge clk);
        en      = e;
        load    = l;
        data_in = d;
        model_step(e, l, d, x);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        cyc++;
        x = sb_q.pop_front();
        check("sb_sel",   16'(sel),        16'(x.sel));
        check("sb_digit", 16'(digit),      16'(x.digit));
        check("sb_blank", 16'(blank),      16'(x.blank));
        check("sb_ftick", 16'(frame_tick), 16'(x.ftick));
        check("sb_ack",   16'(load_ack),   16'(x.ack));
        if (load_ack) ack_cnt++;
    endtask

    task automatic run_to_wrap();
        int n;
        n = 0;
        do begin
            step(1'b1, 1'b0, 16'h0000);
            n++;
        end while (!frame_tick && n < 40);
        check("wrap_seen", 16'(frame_tick), 16'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"},   16'(sel),        16'd0);
        check({tag, "_digit"}, 16'(digit),      16'd0);
        check({tag, "_blank"}, 16'(blank),      16'd1);
        check({tag, "_ftick"}, 16'(frame_tick), 16'd0);
        check({tag, "_ack"},   16'(load_ack),   16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int last_ft;
        int n;
        model_reset();

        // 1: reset state, then free-running scan with an all-zero shadow.
        #12;
        check_reset_outputs("rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        last_ft = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b0, 16'h0000);
            if (i == 4) begin
                check("t1_sel_first", 16'(sel), 16'd1);
                check("t1_blank_sel1", 16'(blank), 16'd0);
            end
            if (i == 16) begin
                check("t1_ftick_16", 16'(frame_tick), 16'd1);
                check("t1_lz_blank", 16'(blank), 16'd1);
            end
            if (frame_tick) begin
                if (last_ft >= 0) check("t1_ft_period", 16'(cyc - last_ft), 16'd16);
                last_ft = cyc;
            end
        end

        // 2: a load mid-frame is shown only after the next wrap.
        step(1'b1, 1'b1, 16'h1234);
        check("t2_no_early_ack", 16'(load_ack), 16'd0);
        ack_cnt = 0;
        run_to_wrap();
        check("t2_ack", 16'(load_ack), 16'd1);
        check("t2_d0", 16'(digit), 16'd1);
        check("t2_b0", 16'(blank), 16'd0);
        for (int k = 1; k <= 3; k++) begin
            repeat (4) step(1'b1, 1'b0, 16'h0000);
            check("t2_sel", 16'(sel), 16'(k));
            check("t2_dk", 16'(digit), 16'(k + 1));
            check("t2_bk", 16'(blank), 16'd0);
        end

        // 3: two loads before a wrap; the last one wins and is acknowledged once.
        ack_cnt = 0;
        step(1'b1, 1'b1, 16'h5678);
        step(1'b1, 1'b1, 16'h0910);
        run_to_wrap();
        check("t3_ack_count", 16'(ack_cnt), 16'd1);
        check("t3_d0", 16'(digit), 16'd0);
        check("t3_lz", 16'(blank), 16'd1);
        repeat (4) step(1'b1, 1'b0, 16'h0000);
        check("t3_d1", 16'(digit), 16'd9);
        check("t3_b1", 16'(blank), 16'd0);

        // 4: a load in the wrap cycle itself is committed on that same wrap.
        n = 0;
        while (!(m_sel == 2'd3 && m_cnt == DIV - 1) && n < 40) begin
            step(1'b1, 1'b0, 16'h0000);
            n++;
        end
        step(1'b1, 1'b1, 16'h4321);
        check("t4_ftick", 16'(frame_tick), 16'd1);
        check("t4_ack", 16'(load_ack), 16'd1);
        check("t4_d0", 16'(digit), 16'd4);
        check("t4_b0", 16'(blank), 16'd0);

        // 5: an invalid BCD nibble is blanked; en=0 freezes the scan and blanks the display.
        ack_cnt = 0;
        step(1'b1, 1'b1, 16'h1A23);
        run_to_wrap();
        check("t5_ack_count", 16'(ack_cnt), 16'd1);
        repeat (4) step(1'b1, 1'b0, 16'h0000);
        check("t5_sel1", 16'(sel), 16'd1);
        check("t5_dA", 16'(digit), 16'hA);
        check("t5_bA", 16'(blank), 16'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 16'h0000);
            check("t5_frz_sel", 16'(sel), 16'd1);
            check("t5_frz_blank", 16'(blank), 16'd1);
        end
        repeat (3) step(1'b1, 1'b0, 16'h0000);
        check("t5_resume_hold", 16'(sel), 16'd1);
        step(1'b1, 1'b0, 16'h0000);
        check("t5_resume_sel", 16'(sel), 16'd2);
        check("t5_resume_d", 16'(digit), 16'd2);
        check("t5_resume_b", 16'(blank), 16'd0);

        // 6: an asynchronous reset mid-frame discards a pending load.
        step(1'b1, 1'b1, 16'h9999);
        step(1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        ack_cnt = 0;
        run_to_wrap();
        check("t6_no_ack", 16'(ack_cnt), 16'd0);
        check("t6_d0", 16'(digit), 16'd0);
        check("t6_b0", 16'(blank), 16'd1);
        repeat (4) step(1'b1, 1'b0, 16'h0000);
        check("t6_d1", 16'(digit), 16'd0);
        check("t6_b1", 16'(blank), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
